// File: rtl/countdown_ctrl.sv
// Front end for the countdown timer: turns start/pause/cancel/ack pulses into
// a load, one decrement every DIV clocks, and a bounded alarm on expiry.
module countdown_ctrl #(
  parameter int N            = 8,
  parameter int DIV          = 4,
  parameter int ALARM_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         cancel,
  input  logic         ack,
  input  logic [N-1:0] preset,
  input  logic         timeup,
  output logic         load,
  output logic [N-1:0] value,
  output logic         decr,
  output logic         busy,
  output logic         paused,
  output logic         alarm
);

  localparam int PW = $clog2(DIV);
  localparam int AW = (ALARM_CYCLES > 0) ? $clog2(ALARM_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'((ALARM_CYCLES > 0) ? (ALARM_CYCLES - 1) : 0);
  localparam bit            ALARM_TIMED = (ALARM_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_presc;
  logic [AW-1:0] r_alarm_cnt;
  logic [N-1:0]  r_value;
  logic          w_alarm_expired;

  assign w_alarm_expired = ALARM_TIMED && (r_alarm_cnt == ALARM_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; cancel outranks start, which outranks ack and pause
  always_comb begin
    w_next_state = r_state;
    if (cancel) begin
      w_next_state = S_IDLE;
    end else if (start) begin
      w_next_state = S_ARM;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_IDLE;
        S_ARM:   w_next_state = S_CHECK;
        S_CHECK: w_next_state = timeup ? S_DONE : S_RUN;
        S_RUN: begin
          if (timeup) begin
            w_next_state = S_DONE;
          end else if (pause) begin
            w_next_state = S_PAUSE;
          end else begin
            w_next_state = S_RUN;
          end
        end
        S_PAUSE: w_next_state = pause ? S_RUN : S_PAUSE;
        S_DONE: begin
          if (ack || w_alarm_expired) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_DONE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Captured preset, prescaler and alarm counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value     <= '0;
      r_presc     <= '0;
      r_alarm_cnt <= '0;
    end else if (cancel) begin
      r_value     <= r_value;
      r_presc     <= r_presc;
      r_alarm_cnt <= r_alarm_cnt;
    end else if (start) begin
      r_value     <= preset;
      r_presc     <= '0;
      r_alarm_cnt <= '0;
    end else begin
      case (r_state)
        S_CHECK: r_presc <= '0;
        S_RUN: begin
          // The prescaler holds in the cycle pause is taken so no tick is lost
          if (!timeup && !pause) begin
            r_presc <= (r_presc == PRESC_MAX) ? '0 : (r_presc + {{(PW-1){1'b0}}, 1'b1});
          end else begin
            r_presc <= r_presc;
          end
        end
        S_DONE: begin
          if (ALARM_TIMED && !w_alarm_expired) begin
            r_alarm_cnt <= r_alarm_cnt + {{(AW-1){1'b0}}, 1'b1};
          end else begin
            r_alarm_cnt <= r_alarm_cnt;
          end
        end
        default: begin
          r_presc     <= r_presc;
          r_alarm_cnt <= r_alarm_cnt;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    load   = 1'b0;
    busy   = 1'b0;
    paused = 1'b0;
    alarm  = 1'b0;
    case (r_state)
      S_ARM: begin
        load = 1'b1;
        busy = 1'b1;
      end
      S_CHECK: busy = 1'b1;
      S_RUN:   busy = 1'b1;
      S_PAUSE: begin
        busy   = 1'b1;
        paused = 1'b1;
      end
      S_DONE:  alarm = 1'b1;
      default: begin
        load   = 1'b0;
        busy   = 1'b0;
        paused = 1'b0;
        alarm  = 1'b0;
      end
    endcase
  end

  assign decr  = (r_state == S_RUN) && (r_presc == PRESC_MAX);
  assign value = r_value;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a behavioural countdown timer attached.
module tb_countdown_ctrl;

  localparam int N = 8;
  localparam int L = 64;

  logic         clk = 1'b0;
  logic         reset, start, pause, cancel, ack;
  logic [N-1:0] preset;
  logic         timeup;
  logic         load, decr, busy, paused, alarm;
  logic [N-1:0] value;
  logic [N-1:0] t_cnt = '0;

  always #5 clk = ~clk;

  countdown_ctrl #(.N(N), .DIV(4), .ALARM_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .cancel(cancel),
    .ack(ack), .preset(preset), .timeup(timeup), .load(load), .value(value),
    .decr(decr), .busy(busy), .paused(paused), .alarm(alarm)
  );

  // Timer model: timeup reflects the registered count
  assign timeup = (t_cnt == 8'd0);
  always @(posedge clk) begin
    if (load) t_cnt <= value;
    else if (decr && t_cnt != 8'd0) t_cnt <= t_cnt - 8'd1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic       ev_reset[L], ev_start[L], ev_pause[L], ev_cancel[L], ev_ack[L];
  logic [7:0] ev_preset[L];
  logic [63:0] tr_load, tr_decr, tr_busy, tr_paused, tr_alarm, tr_timeup;
  logic [7:0]  tr_value[L];

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] bit_at(input int i);
    return 64'd1 << i;
  endfunction

  task automatic clear_ev();
    for (int i = 0; i < L; i++) begin
      ev_reset[i] = 1'b0; ev_start[i] = 1'b0; ev_pause[i] = 1'b0;
      ev_cancel[i] = 1'b0; ev_ack[i] = 1'b0; ev_preset[i] = 8'd0;
    end
  endtask

  // Cycle c: inputs driven after the previous edge, outputs sampled on negedge
  task automatic run(input int len);
    tr_load = '0; tr_decr = '0; tr_busy = '0; tr_paused = '0; tr_alarm = '0; tr_timeup = '0;
    for (int c = 0; c < len; c++) begin
      reset = ev_reset[c]; start = ev_start[c]; pause = ev_pause[c];
      cancel = ev_cancel[c]; ack = ev_ack[c]; preset = ev_preset[c];
      @(negedge clk);
      tr_load[c] = load; tr_decr[c] = decr; tr_busy[c] = busy;
      tr_paused[c] = paused; tr_alarm[c] = alarm; tr_timeup[c] = timeup;
      tr_value[c] = value;
      @(posedge clk);
      #1;
    end
    reset = 1'b0; start = 1'b0; pause = 1'b0; cancel = 1'b0; ack = 1'b0; preset = 8'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_ev();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; cancel = 1'b0; ack = 1'b0; preset = 8'd0;
    @(posedge clk);
    #1;
    check_eq("reset_outputs", {52'd0, load, value, decr, busy, paused, alarm}, 64'd0);
    do_reset();

    // Plain countdown from 3
    ev_start[0] = 1'b1; ev_preset[0] = 8'd3;
    run(40);
    check_eq("s1_load",   tr_load, bit_at(1));
    check_eq("s1_value",  {56'd0, tr_value[1]}, 64'd3);
    check_eq("s1_decr",   tr_decr, bit_at(6) | bit_at(10) | bit_at(14));
    check_eq("s1_busy",   tr_busy, rng(1, 15));
    check_eq("s1_timeup", {62'd0, tr_timeup[15], tr_timeup[14]}, 64'd2);
    check_eq("s1_alarm",  tr_alarm, rng(16, 31));
    check_eq("s1_paused", tr_paused, 64'd0);
    do_reset();

    // Zero preset expires straight out of CHECK
    ev_start[0] = 1'b1; ev_preset[0] = 8'd0;
    run(24);
    check_eq("s2_load",  tr_load, bit_at(1));
    check_eq("s2_decr",  tr_decr, 64'd0);
    check_eq("s2_busy",  tr_busy, rng(1, 2));
    check_eq("s2_alarm", tr_alarm, rng(3, 18));
    do_reset();

    // Pause with prescaler at 2, resume later
    ev_start[0] = 1'b1; ev_preset[0] = 8'd3; ev_pause[5] = 1'b1; ev_pause[20] = 1'b1;
    run(52);
    check_eq("s3_paused", tr_paused, rng(6, 20));
    check_eq("s3_decr",   tr_decr, bit_at(22) | bit_at(26) | bit_at(30));
    check_eq("s3_busy",   tr_busy, rng(1, 31));
    check_eq("s3_alarm",  tr_alarm, rng(32, 47));
    do_reset();

    // Cancel mid-run, then a fresh 2-tick countdown
    ev_start[0] = 1'b1; ev_preset[0] = 8'd5; ev_cancel[8] = 1'b1;
    ev_start[10] = 1'b1; ev_preset[10] = 8'd2;
    run(40);
    check_eq("s4_busy",   tr_busy, rng(1, 8) | rng(11, 21));
    check_eq("s4_load",   tr_load, bit_at(1) | bit_at(11));
    check_eq("s4_value",  {56'd0, tr_value[11]}, 64'd2);
    check_eq("s4_decr",   tr_decr, bit_at(6) | bit_at(16) | bit_at(20));
    check_eq("s4_alarm",  tr_alarm, rng(22, 37));
    do_reset();

    // Ack in the third alarm cycle
    ev_start[0] = 1'b1; ev_preset[0] = 8'd1; ev_ack[10] = 1'b1;
    run(20);
    check_eq("s5a_decr",  tr_decr, bit_at(6));
    check_eq("s5a_alarm", tr_alarm, rng(8, 10));
    do_reset();

    // Restart from DONE
    ev_start[0] = 1'b1; ev_preset[0] = 8'd1; ev_start[9] = 1'b1; ev_preset[9] = 8'd1;
    run(36);
    check_eq("s5b_load",  tr_load, bit_at(1) | bit_at(10));
    check_eq("s5b_decr",  tr_decr, bit_at(6) | bit_at(15));
    check_eq("s5b_alarm", tr_alarm, rng(8, 9) | rng(17, 32));
    do_reset();

    // Reset while running, then stray pause/ack in IDLE
    ev_start[0] = 1'b1; ev_preset[0] = 8'd9; ev_reset[7] = 1'b1;
    ev_pause[10] = 1'b1; ev_ack[12] = 1'b1; ev_pause[14] = 1'b1;
    run(20);
    check_eq("s6_value_pre",  {56'd0, tr_value[7]}, 64'd9);
    check_eq("s6_value_post", {56'd0, tr_value[8]}, 64'd0);
    check_eq("s6_busy",   tr_busy, rng(1, 7));
    check_eq("s6_load",   tr_load, bit_at(1));
    check_eq("s6_decr",   tr_decr, bit_at(6));
    check_eq("s6_idle",   tr_paused | tr_alarm, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
